// File: rtl/irom_spill_merge_pkg.sv
// Shared fetch-stage types: the spill FSM state and the halfword width.
package cvw;
  localparam int HALFWORD = 16;
  typedef enum logic {SPILL_READY = 1'b0, SPILL_SPILL = 1'b1} spillstate_t;
endpackage

// File: rtl/irom_spill_merge_flop.sv
// Async active-high reset flops used by the fetch spill logic.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else       q <= d;
endmodule

module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)   q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/irom_spill_merge.sv
// Merges a 32-bit instruction straddling two ROM words (PCF[1]=1) by issuing a
// second read at PCF+2 and stalling fetch for one cycle.
module irom_spill_merge
  import cvw::*;
#(
  parameter int XLEN       = 64,
  parameter bit COMPRESSED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            FlushF,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [XLEN-1:0] PCF,
  input  logic [31:0]     IROMInstrF,
  output logic [XLEN-1:0] PCSpillNextF,
  output logic [31:0]     InstrRawF,
  output logic            InstrValidF,
  output logic            SpillF
);
  spillstate_t         state_q, state_d;
  logic [0:0]          state_bits_q, state_bits_d;
  logic [HALFWORD-1:0] first_half_q, first_half_d;
  logic [XLEN-1:0]     pc_plus2;
  logic                detect, take_spill;

  assign detect     = COMPRESSED & PCF[1] & (IROMInstrF[1:0] == 2'b11);
  assign take_spill = (state_q == SPILL_READY) & detect & ~StallF & ~FlushF;
  assign pc_plus2   = PCF + XLEN'(2);

  // State register
  assign state_bits_d = state_d;
  assign state_q      = spillstate_t'(state_bits_q);

  flopr #(.WIDTH(1)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (state_bits_d),
    .q     (state_bits_q)
  );

  assign first_half_d = IROMInstrF[HALFWORD-1:0];

  flopenr #(.WIDTH(HALFWORD)) u_first_half (
    .clk   (clk),
    .reset (reset),
    .en    (take_spill),
    .d     (first_half_d),
    .q     (first_half_q)
  );

  // Next state: flush beats stall; a stalled SPILL keeps the captured half.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SPILL_READY: if (take_spill) state_d = SPILL_SPILL;
      SPILL_SPILL: if (FlushF | ~StallF) state_d = SPILL_READY;
      default:     state_d = SPILL_READY;
    endcase
  end

  // Outputs
  always_comb begin
    PCSpillNextF = PCNextF;
    InstrRawF    = IROMInstrF;
    InstrValidF  = 1'b0;
    SpillF       = 1'b0;
    if (!reset) begin
      case (state_q)
        SPILL_READY: begin
          if (FlushF) begin
            InstrValidF = 1'b0;
          end else if (detect) begin
            // Stalled ROM holds its data, so keep re-presenting PCF until released.
            SpillF       = 1'b1;
            PCSpillNextF = StallF ? PCF : pc_plus2;
          end else begin
            InstrValidF = 1'b1;
          end
        end
        SPILL_SPILL: begin
          InstrRawF   = {IROMInstrF[HALFWORD-1:0], first_half_q};
          InstrValidF = ~FlushF;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_irom_spill_merge.sv
// Scoreboard bench for irom_spill_merge: directed cases then random traffic.
module tb_irom_spill_merge;
  localparam int XLEN = 64;

  typedef struct packed {
    logic            rst;
    logic            valid;
    logic            spill;
    logic [XLEN-1:0] pc;
    logic [31:0]     raw;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            StallF = 1'b0;
  logic            FlushF = 1'b0;
  logic [XLEN-1:0] PCNextF = '0;
  logic [XLEN-1:0] PCF = '0;
  logic [31:0]     IROMInstrF = '0;
  logic [XLEN-1:0] PCSpillNextF;
  logic [31:0]     InstrRawF;
  logic            InstrValidF;
  logic            SpillF;

  irom_spill_merge #(.XLEN(XLEN), .COMPRESSED(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .FlushF       (FlushF),
    .PCNextF      (PCNextF),
    .PCF          (PCF),
    .IROMInstrF   (IROMInstrF),
    .PCSpillNextF (PCSpillNextF),
    .InstrRawF    (InstrRawF),
    .InstrValidF  (InstrValidF),
    .SpillF       (SpillF)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [15:0] pend[$];   // low halfword awaiting its upper half
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        m_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // One fetch cycle: drive inputs, predict outputs from the halfword queue.
  task automatic cyc(input logic r, input logic st, input logic fl,
                     input logic [XLEN-1:0] pn, input logic [XLEN-1:0] pf,
                     input logic [31:0] rom);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; StallF = st; FlushF = fl; PCNextF = pn; PCF = pf; IROMInstrF = rom;
    e.rst = r; e.valid = 1'b0; e.spill = 1'b0; e.pc = pn; e.raw = rom;
    if (r) begin
      pend.delete();
    end else if (pend.size() != 0) begin
      e.valid = !fl;
      e.raw   = {rom[15:0], pend[0]};
      if (fl || !st) void'(pend.pop_front());
    end else if (fl) begin
      e.valid = 1'b0;
    end else if (pf[1] && rom[1:0] == 2'b11) begin
      e.spill = 1'b1;
      if (st) e.pc = pf;
      else begin
        e.pc = pf + 64'd2;
        pend.push_back(rom[15:0]);
      end
    end else begin
      e.valid = 1'b1;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      chk("InstrValidF", 64'(InstrValidF), 64'(m_e.valid));
      chk("SpillF", 64'(SpillF), 64'(m_e.spill));
      chk("PCSpillNextF", PCSpillNextF, m_e.pc);
      if (m_e.valid) chk("InstrRawF", 64'(InstrRawF), 64'(m_e.raw));
    end
  end

  initial begin
    logic [XLEN-1:0] top;
    logic [XLEN-1:0] rpc;
    logic [31:0]     rrom;
    top = {XLEN{1'b1}};

    cyc(1, 0, 0, 64'h1000, 64'h0, 32'h0);
    // aligned stream
    cyc(0, 0, 0, 64'h1004, 64'h1000, 32'h00a00513);
    cyc(0, 0, 0, 64'h1008, 64'h1004, 32'h00b00593);
    // basic spill and merge
    cyc(0, 0, 0, 64'h1006, 64'h1002, 32'h00000517);
    cyc(0, 0, 0, 64'h1008, 64'h1002, 32'h00001234);
    // compressed at halfword offset
    cyc(0, 0, 0, 64'h1004, 64'h1002, 32'h00004501);
    // stall while detecting in READY, then proceed
    cyc(0, 1, 0, 64'h2006, 64'h2002, 32'h00000297);
    cyc(0, 0, 0, 64'h2006, 64'h2002, 32'h00000297);
    // stall held in SPILL for 3 cycles, then release
    cyc(0, 1, 0, 64'h2008, 64'h2002, 32'h0000abcd);
    cyc(0, 1, 0, 64'h2008, 64'h2002, 32'h0000abcd);
    cyc(0, 1, 0, 64'h2008, 64'h2002, 32'h0000abcd);
    cyc(0, 0, 0, 64'h2008, 64'h2002, 32'h0000abcd);
    cyc(0, 0, 0, 64'h2008, 64'h2004, 32'h00000003);
    // flush during SPILL
    cyc(0, 0, 0, 64'h3006, 64'h3002, 32'h000000b7);
    cyc(0, 0, 1, 64'h8000, 64'h3002, 32'h00005555);
    cyc(0, 0, 0, 64'h8004, 64'h8000, 32'h00000013);
    // reset asserted while in SPILL
    cyc(0, 0, 0, 64'h4006, 64'h4002, 32'h00000037);
    cyc(1, 0, 0, 64'h4008, 64'h4002, 32'h00007777);
    cyc(0, 0, 0, 64'h0004, 64'h0000, 32'h00000033);
    // PC+2 wraps to zero
    cyc(0, 0, 0, 64'h0, top - 64'd1, 32'h00000517);
    cyc(0, 0, 0, 64'h4, top - 64'd1, 32'h0000beef);

    for (int i = 0; i < 3000; i++) begin
      rpc  = {$urandom(), $urandom()};
      rpc[0] = 1'b0;
      rrom = $urandom();
      if ($urandom_range(0, 9) < 7) rrom[1:0] = 2'b11;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, {$urandom(), $urandom()}, rpc, rrom);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
